// File: rtl/program_memory_loader.sv
// Byte-stream program loader: packs big-endian bytes into words and writes program memory.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_memory_loader #(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000,
  localparam int         CW = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  input  logic          byte_last_i,
  output logic          byte_ready_o,
  output logic          mem_write_o,
  output logic [31:0]   mem_address_o,
  output logic [31:0]   mem_data_o,
  output logic          cpu_hold_o,
  output logic          load_done_o,
  output logic [CW-1:0] word_count_o,
  output logic          overflow_error_o,
  output logic          checksum_error_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          last_q, last_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          hold_q, hold_d;
  logic          ovf_q, ovf_d;
  logic          chk_q, chk_d;
  logic [31:0]   word_v;
  logic          accept;
  logic          full;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
  logic          sum_bad;
`endif

  assign accept = byte_valid_i && (state_q == LOAD);
  assign full   = (wcnt_q == CW'(MEMORY_DEPTH));
  assign word_v = shift_q | ({byte_data_i, 24'h0} >> {bcnt_q, 3'b000});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign sum_bad = (byte_data_i != xor_q);
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    chk_d   = chk_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = LOAD;
          shift_d = '0;
          bcnt_d  = '0;
          wcnt_d  = '0;
          last_d  = 1'b0;
          hold_d  = 1'b1;
          ovf_d   = 1'b0;
          chk_d   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          if (full) begin
            // memory exhausted: drop the byte, still honour end of image
            ovf_d = 1'b1;
            if (byte_last_i) begin
              state_d = DONE;
              hold_d  = 1'b0;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          end else if (byte_last_i) begin
            chk_d  = sum_bad;
            hold_d = sum_bad;
            if (bcnt_q == 2'd0) begin
              state_d = DONE;
            end else begin
              state_d = WRITE;
              addr_d  = BASE_ADDRESS + (32'(wcnt_q) << 2);
              data_d  = shift_q;
              shift_d = '0;
              bcnt_d  = '0;
              last_d  = 1'b1;
            end
`endif
          end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_d = xor_q ^ byte_data_i;
`endif
            if (bcnt_q == 2'd3 || byte_last_i) begin
              state_d = WRITE;
              addr_d  = BASE_ADDRESS + (32'(wcnt_q) << 2);
              data_d  = word_v;
              shift_d = '0;
              bcnt_d  = '0;
              last_d  = byte_last_i;
            end else begin
              shift_d = word_v;
              bcnt_d  = bcnt_q + 2'd1;
            end
          end
        end
      end
      WRITE: begin
        wcnt_d = wcnt_q + CW'(1);
        if (last_q) begin
          state_d = DONE;
          hold_d  = chk_q;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      ovf_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      chk_q   <= chk_d;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xor_q <= '0;
    else        xor_q <= xor_d;
  end
  assign checksum_error_o = chk_q;
`else
  assign checksum_error_o = 1'b0;
`endif

  assign byte_ready_o     = (state_q == LOAD);
  assign mem_write_o      = (state_q == WRITE);
  assign load_done_o      = (state_q == DONE);
  assign mem_address_o    = addr_q;
  assign mem_data_o       = data_q;
  assign cpu_hold_o       = hold_q;
  assign word_count_o     = wcnt_q;
  assign overflow_error_o = ovf_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: default depth instance plus a depth-2 instance.
// Default build (checksum feature disabled).
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = '0;
  logic        last = 1'b0;

  logic        ready_a, wr_a, hold_a, done_a, ovf_a, chk_a;
  logic [31:0] addr_a, wdata_a;
  logic [5:0]  cnt_a;
  logic        ready_b, wr_b, hold_b, done_b, ovf_b, chk_b;
  logic [31:0] addr_b, wdata_b;
  logic [1:0]  cnt_b;

  int tests = 0;
  int failed = 0;
  bit sel_b = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int nwr_b = 0;

  always #5 clk = ~clk;

  program_memory_loader u_dut (
    .clk(clk), .reset(rst_n), .start_i(start_a),
    .byte_valid_i(valid && !sel_b), .byte_data_i(data),
    .byte_last_i(last), .byte_ready_o(ready_a),
    .mem_write_o(wr_a), .mem_address_o(addr_a),
    .mem_data_o(wdata_a), .cpu_hold_o(hold_a),
    .load_done_o(done_a), .word_count_o(cnt_a),
    .overflow_error_o(ovf_a), .checksum_error_o(chk_a)
  );

  program_memory_loader #(.MEMORY_DEPTH(2)) u_small (
    .clk(clk), .reset(rst_n), .start_i(start_b),
    .byte_valid_i(valid && sel_b), .byte_data_i(data),
    .byte_last_i(last), .byte_ready_o(ready_b),
    .mem_write_o(wr_b), .mem_address_o(addr_b),
    .mem_data_o(wdata_b), .cpu_hold_o(hold_b),
    .load_done_o(done_b), .word_count_o(cnt_b),
    .overflow_error_o(ovf_b), .checksum_error_o(chk_b)
  );

  always @(posedge clk) begin
    if (wr_a) begin
      wa_q.push_back(addr_a);
      wd_q.push_back(wdata_a);
    end
    if (wr_b) nwr_b <= nwr_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int n;
    @(negedge clk);
    valid = 1'b1;
    data  = b;
    last  = l;
    n = 0;
    while (!(sel_b ? ready_b : ready_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic drop;
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!(sel_b ? done_b : done_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'd0, n >= 100}, 32'd0);
  endtask

  initial begin
    // Test 1: reset behaviour, including reset asserted while idle
    #12;
    check("rst_hold", hold_a, 1);
    check("rst_ready", ready_a, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("idle_rst_hold", hold_a, 1);
    check("idle_rst_ready", ready_a, 0);
    check("idle_rst_wr", wr_a, 0);
    check("idle_rst_done", done_a, 0);
    check("idle_rst_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 2: single full word
    pulse_start(0);
    send(8'h20, 0);
    #1;
    check("t2_hold_loading", hold_a, 1);
    send(8'h08, 0);
    send(8'h00, 0);
    send(8'h05, 1);
    drop();
    wait_done();
    check("t2_nwr", 32'(wa_q.size()), 1);
    check("t2_addr", wa_q[0], 32'h0040_0000);
    check("t2_data", wd_q[0], 32'h2008_0005);
    check("t2_done", done_a, 1);
    check("t2_hold", hold_a, 0);
    check("t2_cnt", 32'(cnt_a), 1);
    check("t2_addr_hold", addr_a, 32'h0040_0000);

    // Test 3: restart from DONE, trailing partial word
    wa_q.delete();
    wd_q.delete();
    pulse_start(0);
    check("t3_hold_restart", hold_a, 1);
    check("t3_cnt_cleared", 32'(cnt_a), 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    send(8'hDD, 0);
    send(8'h11, 0);
    send(8'h22, 1);
    drop();
    wait_done();
    check("t3_nwr", 32'(wa_q.size()), 2);
    check("t3_addr0", wa_q[0], 32'h0040_0000);
    check("t3_data0", wd_q[0], 32'hAABB_CCDD);
    check("t3_addr1", wa_q[1], 32'h0040_0004);
    check("t3_data1", wd_q[1], 32'h1122_0000);
    check("t3_cnt", 32'(cnt_a), 2);
    check("t3_data_hold", wdata_a, 32'h1122_0000);

    // Test 4: valid stays high across WRITE cycles
    wa_q.delete();
    wd_q.delete();
    pulse_start(0);
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    drop();
    wait_done();
    check("t4_nwr", 32'(wa_q.size()), 2);
    check("t4_data0", wd_q[0], 32'h0102_0304);
    check("t4_data1", wd_q[1], 32'h0506_0708);
    check("t4_addr1", wa_q[1], 32'h0040_0004);
    check("t4_ovf", ovf_a, 0);

    // Test 5: depth-2 memory overflows
    sel_b = 1'b1;
    pulse_start(1);
    for (int i = 1; i <= 12; i++) send(8'(8'h40 + i), i == 12);
    drop();
    wait_done();
    check("t5_nwr", 32'(nwr_b), 2);
    check("t5_ovf", ovf_b, 1);
    check("t5_done", done_b, 1);
    check("t5_cnt", 32'(cnt_b), 2);
    check("t5_last_data", wdata_b, 32'h4546_4748);
    check("t5_last_addr", addr_b, 32'h0040_0004);
    sel_b = 1'b0;

    // Test 6: reset mid-load, then a clean load
    wa_q.delete();
    wd_q.delete();
    pulse_start(0);
    send(8'hA1, 0);
    send(8'hA2, 0);
    drop();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", ready_a, 0);
    check("t6_rst_hold", hold_a, 1);
    check("t6_rst_addr", addr_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    send(8'h31, 0);
    send(8'h32, 0);
    send(8'h33, 0);
    send(8'h34, 1);
    drop();
    wait_done();
    check("t6_nwr", 32'(wa_q.size()), 1);
    check("t6_addr", wa_q[0], 32'h0040_0000);
    check("t6_data", wd_q[0], 32'h3132_3334);
    check("t6_chk", chk_a, 0);
    check("t6_hold", hold_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
